// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/ready bus between the MEM-stage LSU (master) and data memory (slave).
// Single outstanding access; read data is valid only while dmem_ready_i is high.
interface mem_stage_lsu_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ready_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_be_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_rdata_i,
        input  dmem_ready_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_be_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_rdata_i,
        output dmem_ready_i
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: issues sized loads/stores on a req/ready bus, extends load data,
// flags misaligned accesses and bus timeouts, and holds the MEM/WB register.
module mem_stage_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   RegWrite_i,
    input  logic                   MemtoReg_i,
    input  logic                   MemRead_i,
    input  logic                   MemWrite_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            ALUout_i,
    input  logic [31:0]            DM_writedata_i,
    input  logic [4:0]             rd_i,
    output logic                   stall_o,
    mem_stage_lsu_if.master        dmem,
    output logic                   RegWrite_o,
    output logic                   MemtoReg_o,
    output logic [31:0]            ALUout_o,
    output logic [31:0]            MemData_o,
    output logic [4:0]             rd_o,
    output logic                   misalign_o,
    output logic                   bus_err_o
);
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Bus request registers
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    // Instruction fields latched in IDLE so WAIT is independent of upstream
    logic              lat_regwrite_q, lat_regwrite_d;
    logic              lat_memtoreg_q, lat_memtoreg_d;
    logic [2:0]        lat_funct3_q, lat_funct3_d;
    logic [31:0]       lat_alu_q, lat_alu_d;
    logic [4:0]        lat_rd_q, lat_rd_d;

    // MEM/WB register and event pulses
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [31:0]       aluout_q, aluout_d;
    logic [31:0]       memdata_q, memdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              is_mem_op;
    logic              size_ok;
    logic [1:0]        lane_sel;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [31:0]       lane;
    logic [31:0]       load_data;
    logic              stall;

    assign is_mem_op = MemRead_i | MemWrite_i;
    assign lane_sel  = ALUout_i[1:0];

    // Size decode, lane enables and store-data replication for the incoming access
    always_comb begin
        size_ok    = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = DM_writedata_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                size_ok    = 1'b1;
                be_calc    = 4'b0001 << lane_sel;
                wdata_calc = {4{DM_writedata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                size_ok    = ~lane_sel[0];
                be_calc    = 4'b0011 << lane_sel;
                wdata_calc = {2{DM_writedata_i[15:0]}};
            end
            3'b010: begin
                size_ok    = (lane_sel == 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = DM_writedata_i;
            end
            default: begin
                size_ok = 1'b0;
            end
        endcase
    end

    // Load lane selection and extension using the latched address/size
    always_comb begin
        lane = dmem.dmem_rdata_i >> {lat_alu_q[1:0], 3'b000};
        case (lat_funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'h000000, lane[7:0]};
            3'b101:  load_data = {16'h0000, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        be_d           = be_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_funct3_d   = lat_funct3_q;
        lat_alu_d      = lat_alu_q;
        lat_rd_d       = lat_rd_q;
        // MEM/WB defaults to a bubble
        regwrite_d     = 1'b0;
        memtoreg_d     = 1'b0;
        aluout_d       = 32'h0;
        memdata_d      = 32'h0;
        rd_d           = 5'd0;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;
        stall          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!is_mem_op) begin
                    regwrite_d = RegWrite_i;
                    memtoreg_d = MemtoReg_i;
                    aluout_d   = ALUout_i;
                    rd_d       = rd_i;
                end else if (size_ok) begin
                    stall          = 1'b1;
                    req_d          = 1'b1;
                    we_d           = MemWrite_i;
                    be_d           = be_calc;
                    addr_d         = {ALUout_i[31:2], 2'b00};
                    wdata_d        = wdata_calc;
                    cnt_d          = '0;
                    lat_regwrite_d = RegWrite_i;
                    lat_memtoreg_d = MemtoReg_i;
                    lat_funct3_d   = funct3_i;
                    lat_alu_d      = ALUout_i;
                    lat_rd_d       = rd_i;
                    state_d        = StWait;
                end else begin
                    misalign_d = 1'b1;
                end
            end
            StWait: begin
                stall = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (dmem.dmem_ready_i) begin
                    stall      = 1'b0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    regwrite_d = lat_regwrite_q;
                    memtoreg_d = lat_memtoreg_q;
                    aluout_d   = lat_alu_q;
                    rd_d       = lat_rd_q;
                    memdata_d  = we_q ? 32'h0 : load_data;
                    state_d    = StIdle;
                end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
                    // Timeout: consume the instruction and release the pipeline
                    stall     = 1'b0;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            be_q           <= 4'b0000;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_funct3_q   <= 3'b000;
            lat_alu_q      <= 32'h0;
            lat_rd_q       <= 5'd0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            aluout_q       <= 32'h0;
            memdata_q      <= 32'h0;
            rd_q           <= 5'd0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_funct3_q   <= lat_funct3_d;
            lat_alu_q      <= lat_alu_d;
            lat_rd_q       <= lat_rd_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            aluout_q       <= aluout_d;
            memdata_q      <= memdata_d;
            rd_q           <= rd_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign stall_o           = stall;
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign RegWrite_o        = regwrite_q;
    assign MemtoReg_o        = memtoreg_q;
    assign ALUout_o          = aluout_q;
    assign MemData_o         = memdata_q;
    assign rd_o              = rd_q;
    assign misalign_o        = misalign_q;
    assign bus_err_o         = bus_err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU pass-through, sized loads/stores, misalignment,
// bus timeout (MAX_WAIT=4) and reset during an outstanding access.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUout_i, DM_writedata_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUout_o, MemData_o;
    logic [4:0]  rd_o;
    logic        misalign_o, bus_err_o;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.MAX_WAIT(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .RegWrite_i     (RegWrite_i),
        .MemtoReg_i     (MemtoReg_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .funct3_i       (funct3_i),
        .ALUout_i       (ALUout_i),
        .DM_writedata_i (DM_writedata_i),
        .rd_i           (rd_i),
        .stall_o        (stall_o),
        .dmem           (bus.master),
        .RegWrite_o     (RegWrite_o),
        .MemtoReg_o     (MemtoReg_o),
        .ALUout_o       (ALUout_o),
        .MemData_o      (MemData_o),
        .rd_o           (rd_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rw, input logic m2r, input logic rdn, input logic wrn,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd);
        RegWrite_i     = rw;
        MemtoReg_i     = m2r;
        MemRead_i      = rdn;
        MemWrite_i     = wrn;
        funct3_i       = f3;
        ALUout_i       = alu;
        DM_writedata_i = wd;
        rd_i           = rd;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        bus.dmem_ready_i = 1'b0;
        bus.dmem_rdata_i = 32'h0;
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        step();
        step();
        rst_i = 1'b0;
        chk("reset_regwrite", {31'b0, RegWrite_o}, 32'h0);
        chk("reset_req", {31'b0, bus.dmem_req_o}, 32'h0);
        chk("reset_memdata", MemData_o, 32'h0);
        chk("reset_pulses", {30'b0, misalign_o, bus_err_o}, 32'h0);

        // 1: ALU op passes through in one cycle
        set_op(1, 0, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        chk("alu_stall", {31'b0, stall_o}, 32'h0);
        step();
        chk("alu_regwrite", {31'b0, RegWrite_o}, 32'h1);
        chk("alu_aluout", ALUout_o, 32'h0000_1234);
        chk("alu_rd", {27'b0, rd_o}, 32'd5);
        chk("alu_memdata", MemData_o, 32'h0);

        // 2: LB at 0x103, ready on the 4th WAIT cycle
        set_op(1, 1, 1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        chk("lb_stall_idle", {31'b0, stall_o}, 32'h1);
        step();
        set_op(0, 0, 0, 0, 3'b111, 32'hDEAD_BEEF, 32'h0, 5'd31);
        chk("lb_req", {31'b0, bus.dmem_req_o}, 32'h1);
        chk("lb_we", {31'b0, bus.dmem_we_o}, 32'h0);
        chk("lb_be", {28'b0, bus.dmem_be_o}, 32'b1000);
        chk("lb_addr", bus.dmem_addr_o, 32'h0000_0100);
        chk("lb_bubble", {31'b0, RegWrite_o}, 32'h0);
        chk("lb_stall_w1", {31'b0, stall_o}, 32'h1);
        step();
        chk("lb_stall_w2", {31'b0, stall_o}, 32'h1);
        step();
        chk("lb_stall_w3", {31'b0, stall_o}, 32'h1);
        step();
        bus.dmem_ready_i = 1'b1;
        bus.dmem_rdata_i = 32'h80FF_0000;
        #1;
        chk("lb_stall_ready", {31'b0, stall_o}, 32'h0);
        step();
        bus.dmem_ready_i = 1'b0;
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("lb_req_drop", {31'b0, bus.dmem_req_o}, 32'h0);
        chk("lb_memdata", MemData_o, 32'hFFFF_FF80);
        chk("lb_regwrite", {31'b0, RegWrite_o}, 32'h1);
        chk("lb_memtoreg", {31'b0, MemtoReg_o}, 32'h1);
        chk("lb_rd", {27'b0, rd_o}, 32'd7);
        chk("lb_aluout", ALUout_o, 32'h0000_0103);

        // LBU at 0x101, immediate ready
        set_op(1, 1, 1, 0, 3'b100, 32'h0000_0101, 32'h0, 5'd4);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("lbu_be", {28'b0, bus.dmem_be_o}, 32'b0010);
        bus.dmem_ready_i = 1'b1;
        bus.dmem_rdata_i = 32'h0000_9A00;
        step();
        bus.dmem_ready_i = 1'b0;
        chk("lbu_memdata", MemData_o, 32'h0000_009A);

        // 3: SH at 0x202, ready in the first WAIT cycle
        set_op(1, 0, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd9);
        chk("sh_stall_idle", {31'b0, stall_o}, 32'h1);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("sh_we", {31'b0, bus.dmem_we_o}, 32'h1);
        chk("sh_be", {28'b0, bus.dmem_be_o}, 32'b1100);
        chk("sh_wdata", bus.dmem_wdata_o, 32'hABCD_ABCD);
        chk("sh_addr", bus.dmem_addr_o, 32'h0000_0200);
        bus.dmem_ready_i = 1'b1;
        #1;
        chk("sh_stall_ready", {31'b0, stall_o}, 32'h0);
        step();
        bus.dmem_ready_i = 1'b0;
        chk("sh_regwrite", {31'b0, RegWrite_o}, 32'h1);
        chk("sh_memdata", MemData_o, 32'h0);
        chk("sh_req_drop", {31'b0, bus.dmem_req_o}, 32'h0);

        // SW with RegWrite_i=0
        set_op(0, 0, 0, 1, 3'b010, 32'h0000_0300, 32'h1122_3344, 5'd2);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("sw_be", {28'b0, bus.dmem_be_o}, 32'b1111);
        chk("sw_wdata", bus.dmem_wdata_o, 32'h1122_3344);
        bus.dmem_ready_i = 1'b1;
        step();
        bus.dmem_ready_i = 1'b0;
        chk("sw_regwrite", {31'b0, RegWrite_o}, 32'h0);

        // 4: LW at 0x101 is misaligned
        set_op(1, 1, 1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd8);
        chk("lw_mis_stall", {31'b0, stall_o}, 32'h0);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("lw_mis_pulse", {31'b0, misalign_o}, 32'h1);
        chk("lw_mis_req", {31'b0, bus.dmem_req_o}, 32'h0);
        chk("lw_mis_regwrite", {31'b0, RegWrite_o}, 32'h0);
        step();
        chk("lw_mis_pulse_end", {31'b0, misalign_o}, 32'h0);

        // Illegal funct3 011 is flagged even when aligned
        set_op(1, 0, 1, 0, 3'b011, 32'h0000_0000, 32'h0, 5'd8);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("f3_011_mis", {31'b0, misalign_o}, 32'h1);
        chk("f3_011_req", {31'b0, bus.dmem_req_o}, 32'h0);

        // 5: LHU with no ready times out after 4 WAIT cycles
        set_op(1, 1, 1, 0, 3'b101, 32'h0000_0040, 32'h0, 5'd6);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("to_stall_w1", {31'b0, stall_o}, 32'h1);
        step();
        step();
        chk("to_stall_w3", {31'b0, stall_o}, 32'h1);
        step();
        chk("to_stall_w4", {31'b0, stall_o}, 32'h0);
        chk("to_no_err_yet", {31'b0, bus_err_o}, 32'h0);
        step();
        set_op(1, 0, 0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd3);
        chk("to_bus_err", {31'b0, bus_err_o}, 32'h1);
        chk("to_req_drop", {31'b0, bus.dmem_req_o}, 32'h0);
        chk("to_regwrite", {31'b0, RegWrite_o}, 32'h0);
        chk("to_next_stall", {31'b0, stall_o}, 32'h0);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("to_err_end", {31'b0, bus_err_o}, 32'h0);
        chk("to_next_regwrite", {31'b0, RegWrite_o}, 32'h1);
        chk("to_next_aluout", ALUout_o, 32'h0000_0055);

        // 6: reset during WAIT, then a late ready
        set_op(1, 1, 1, 0, 3'b010, 32'h0000_0010, 32'h0, 5'd12);
        step();
        set_op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("rst_req_before", {31'b0, bus.dmem_req_o}, 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("rst_req", {31'b0, bus.dmem_req_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_memwb", {RegWrite_o, MemtoReg_o, rd_o}, 32'h0);
        chk("rst_aluout", ALUout_o, 32'h0);
        bus.dmem_ready_i = 1'b1;
        bus.dmem_rdata_i = 32'hFFFF_FFFF;
        step();
        bus.dmem_ready_i = 1'b0;
        chk("late_ready_regwrite", {31'b0, RegWrite_o}, 32'h0);
        chk("late_ready_memdata", MemData_o, 32'h0);
        chk("late_ready_req", {31'b0, bus.dmem_req_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
